// File: rtl/imem_store_buffer.sv
// Store buffer that queues data-path stores to the IMEM window and drains them into the IMEM write port.
// Optional macro STB_COALESCE_EN merges a store into the tail entry when the word addresses match.
module imem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [31:0]                st_addr,
  input  logic [31:0]                st_data,
  input  logic [3:0]                 st_wmask,
  input  logic                       imem_wr_gnt,
  output logic [3:0]                 imem_we,
  output logic [AW-1:0]              imem_waddr,
  output logic [31:0]                imem_wdata,
  input  logic [31:0]                fetch_pc,
  output logic                       fetch_hold,
  input  logic                       fence_i,
  output logic                       fence_busy,
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [0:0] {S_IDLE, S_FENCE} state_t;

  state_t          r_state;
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_addr [DEPTH];
  logic [31:0]     r_data [DEPTH];
  logic [3:0]      r_mask [DEPTH];

  logic            w_full;
  logic            w_empty;
  logic            w_enq;
  logic            w_push;
  logic            w_pop;
  logic            w_merge;
  logic [AW-1:0]   w_st_wa;
  logic [AW-1:0]   w_fetch_wa;
  logic            w_hazard;
  logic [PW-1:0]   w_rel;
  logic            w_unused_bits;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign st_ready   = !rst && (r_state == S_IDLE) && !w_full;
  assign w_st_wa    = st_addr[AW+1:2];
  assign w_fetch_wa = fetch_pc[AW+1:2];
  // Stores outside the window or with an empty mask are acknowledged but never queued.
  assign w_enq      = st_valid && st_ready && (st_addr[31:29] == 3'b001) && (st_wmask != 4'b0);
  assign w_pop      = !rst && !w_empty && imem_wr_gnt;
  assign w_push     = w_enq && !w_merge;

`ifdef STB_COALESCE_EN
  logic [PW-1:0] w_tail;
  assign w_tail  = r_wptr - 1'b1;
  // A tail entry that is also the head leaving this cycle cannot absorb the store.
  assign w_merge = w_enq && !w_empty && (r_addr[w_tail] == w_st_wa) &&
                   !((r_count == CW'(1)) && w_pop);
`else
  assign w_merge = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      case (r_state)
        S_IDLE:  if (fence_i) r_state <= S_FENCE;
        S_FENCE: if (r_count == '0) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wptr] <= w_st_wa;
      r_data[r_wptr] <= st_data;
      r_mask[r_wptr] <= st_wmask;
    end
`ifdef STB_COALESCE_EN
    if (w_merge) begin
      for (int i = 0; i < 4; i++) begin
        if (st_wmask[i]) r_data[w_tail][8*i +: 8] <= st_data[8*i +: 8];
      end
      r_mask[w_tail] <= r_mask[w_tail] | st_wmask;
    end
`endif
  end

  assign imem_we    = w_pop   ? r_mask[r_rptr] : 4'b0;
  assign imem_waddr = w_empty ? '0 : r_addr[r_rptr];
  assign imem_wdata = w_empty ? '0 : r_data[r_rptr];
  assign fence_busy = (r_state == S_FENCE);
  assign occupancy  = r_count;

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    w_hazard = 1'b0;
    w_rel    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_rel = PW'(i) - r_rptr;
      if ((CW'(w_rel) < r_count) && (r_addr[i] == w_fetch_wa)) w_hazard = 1'b1;
    end
    if (w_enq && (w_st_wa == w_fetch_wa)) w_hazard = 1'b1;
  end

  assign fetch_hold = (fetch_pc[31:29] == 3'b000) && fetch_pc[28] && w_hazard;

  assign w_unused_bits = ^{st_addr[28:AW+2], st_addr[1:0], fetch_pc[27:AW+2], fetch_pc[1:0]};
endmodule
